sobel_frame_ctrl: RTL

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame sequencer around an external colour filter. It streams one frame of
// IMG_W*IMG_H pixels from a source memory into the filter. It then joins the
// filter's three independent 8-bit channel outputs back into 24-bit pixels.
// These pixels are written to a result memory in input order.
//
// Handshake (every vld/busy pair on this block):
//   A transfer happens in a cycle where vld=1 and busy=0. The producer holds
//   vld and data stable until that cycle.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                begin one frame (sampled in IDLE only)
//   o_busy                 frame in progress
//   o_done                 one-cycle pulse when the frame is complete
//   o_rd_en / o_rd_addr    source memory read; data returns one cycle later
//   i_rd_data              source pixel
//   o_rgb_vld / o_rgb_data pixel toward the filter, i_rgb_busy stalls it
//   i_newX_vld / _data     filter channel results (X = R, G, B)
//   o_newX_busy            per-channel stall toward the filter
//   o_wr_en / _addr / _data result memory write, data = {R, G, B}
//   o_state                current FSM state (IDLE=0 FETCH=1 FEED=2
//                          DRAIN=3 DONE=4), for observation only
//
// IMG_W*IMG_H must not exceed 2**AW.
// ---------------------------------------------------------------------------
module sobel_frame_ctrl #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [23:0]   i_rd_data,
    output logic          o_rgb_vld,
    output logic [23:0]   o_rgb_data,
    input  logic          i_rgb_busy,
    input  logic          i_newR_vld,
    input  logic          i_newG_vld,
    input  logic          i_newB_vld,
    input  logic [7:0]    i_newR_data,
    input  logic [7:0]    i_newG_data,
    input  logic [7:0]    i_newB_data,
    output logic          o_newR_busy,
    output logic          o_newG_busy,
    output logic          o_newB_busy,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [23:0]   o_wr_data,
    output logic [2:0]    o_state
);

    // Counters are one bit wider than the address so they can hold N itself.
    localparam logic [AW:0] PIX_LAST  = (AW+1)'(IMG_W * IMG_H - 1);
    localparam logic [AW:0] PIX_TOTAL = (AW+1)'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT         state;
    logic [AW:0]   inCnt;
    logic [AW:0]   outCnt;

    logic          busyQ;
    logic          doneQ;
    logic          rdEnQ;
    logic [AW-1:0] rdAddrQ;
    logic          rgbVldQ;
    logic          rgbFirst;   // first FEED cycle: memory data is on i_rd_data
    logic [23:0]   rgbHold;    // pixel held for the rest of a stalled FEED

    logic          flagR;
    logic          flagG;
    logic          flagB;
    logic [7:0]    dataR;
    logic [7:0]    dataG;
    logic [7:0]    dataB;

    logic          chanBusyR;
    logic          chanBusyG;
    logic          chanBusyB;
    logic          xferR;
    logic          xferG;
    logic          xferB;
    logic          wrEn;

    // -----------------------------------------------------------------------
    // Joiner: combinational part.
    // A channel arriving in the same cycle as the last missing flag completes
    // the pixel straight away. The write then goes out in that cycle with
    // the arriving byte passed through, and all flags are clear afterwards.
    // In IDLE every channel is stalled, so stray filter output cannot land.
    // -----------------------------------------------------------------------
    always_comb begin
        chanBusyR = (state == IDLE) ? 1'b1 : flagR;
        chanBusyG = (state == IDLE) ? 1'b1 : flagG;
        chanBusyB = (state == IDLE) ? 1'b1 : flagB;

        xferR = i_newR_vld && !chanBusyR;
        xferG = i_newG_vld && !chanBusyG;
        xferB = i_newB_vld && !chanBusyB;

        wrEn = (flagR || xferR) && (flagG || xferG) && (flagB || xferB)
               && (state != IDLE);
    end

    assign o_newR_busy = chanBusyR;
    assign o_newG_busy = chanBusyG;
    assign o_newB_busy = chanBusyB;

    assign o_wr_en   = wrEn;
    assign o_wr_addr = outCnt[AW-1:0];
    assign o_wr_data = {xferR ? i_newR_data : dataR,
                        xferG ? i_newG_data : dataG,
                        xferB ? i_newB_data : dataB};

    // The first FEED cycle forwards the memory word directly, so the pixel
    // is offered two cycles after start. Later cycles of the same FEED use
    // the captured copy, which keeps the data stable while stalled.
    assign o_rgb_data = rgbFirst ? i_rd_data : rgbHold;

    assign o_busy    = busyQ;
    assign o_done    = doneQ;
    assign o_rd_en   = rdEnQ;
    assign o_rd_addr = rdAddrQ;
    assign o_rgb_vld = rgbVldQ;
    assign o_state   = state;

    // -----------------------------------------------------------------------
    // Sequencer and joiner state.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            inCnt    <= '0;
            outCnt   <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            rdEnQ    <= 1'b0;
            rdAddrQ  <= '0;
            rgbVldQ  <= 1'b0;
            rgbFirst <= 1'b0;
            rgbHold  <= '0;
            flagR    <= 1'b0;
            flagG    <= 1'b0;
            flagB    <= 1'b0;
            dataR    <= '0;
            dataG    <= '0;
            dataB    <= '0;
        end else begin
            // Strobes default low; the FSM raises them for one cycle.
            doneQ <= 1'b0;
            rdEnQ <= 1'b0;

            // Joiner bookkeeping runs in every non-IDLE state.
            if (wrEn) begin
                flagR  <= 1'b0;
                flagG  <= 1'b0;
                flagB  <= 1'b0;
                outCnt <= outCnt + 1'b1;
            end else begin
                if (xferR) begin
                    flagR <= 1'b1;
                    dataR <= i_newR_data;
                end
                if (xferG) begin
                    flagG <= 1'b1;
                    dataG <= i_newG_data;
                end
                if (xferB) begin
                    flagB <= 1'b1;
                    dataB <= i_newB_data;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= FETCH;
                        busyQ   <= 1'b1;
                        inCnt   <= '0;
                        outCnt  <= '0;
                        flagR   <= 1'b0;
                        flagG   <= 1'b0;
                        flagB   <= 1'b0;
                        rdEnQ   <= 1'b1;
                        rdAddrQ <= '0;
                    end
                end

                FETCH: begin
                    state    <= FEED;
                    rgbVldQ  <= 1'b1;
                    rgbFirst <= 1'b1;
                end

                FEED: begin
                    rgbFirst <= 1'b0;
                    if (rgbFirst) begin
                        rgbHold <= i_rd_data;
                    end
                    if (!i_rgb_busy) begin
                        rgbVldQ <= 1'b0;
                        inCnt   <= inCnt + 1'b1;
                        if (inCnt == PIX_LAST) begin
                            state <= DRAIN;
                        end else begin
                            state   <= FETCH;
                            rdEnQ   <= 1'b1;
                            rdAddrQ <= AW'(inCnt + 1'b1);
                        end
                    end
                end

                DRAIN: begin
                    // outCnt is registered, so this sees the count one cycle
                    // after the final write.
                    if (outCnt == PIX_TOTAL) begin
                        state <= DONE;
                        doneQ <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                end
            endcase
        end
    end

endmodule
